// File: rtl/alu_seq_core.sv
// alu_seq_core: handshaked ALU with single-cycle arithmetic/logic/shift/compare
// ops and an iterative shift-add unsigned multiply (WIDTH cycles).
//
// Optional feature macro: ALU_SAT_EN
//   defined   -> opcodes 1100 ADDS / 1101 SUBS are signed saturating ops
//   undefined -> 1100 / 1101 are reported as illegal
//
// Ports:
//   clock, reset_n           clock, async active-low reset
//   in_valid / in_ready      operation handshake (in_ready is combinational)
//   opcode, operand_a/b      operation select and operands (b = shift amount)
//   out_valid / out_ready    result handshake
//   result, result_hi        low word, high word (MUL only, else 0)
//   zero/carry/overflow/illegal_flag  status of the held result
//   busy                     multiply in progress
//
// FSM states:
//   state | meaning
//   IDLE  | ready for a new operation (subject to output backpressure)
//   MUL   | shift-add multiply running, one multiplier bit per cycle

module alu_seq_core #(
  parameter int WIDTH = 8,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       opcode,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             zero_flag,
  output logic             carry_flag,
  output logic             overflow_flag,
  output logic             illegal_flag,
  output logic             busy
);

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_AND  = 4'h2;
  localparam logic [3:0] OP_OR   = 4'h3;
  localparam logic [3:0] OP_XOR  = 4'h4;
  localparam logic [3:0] OP_NOR  = 4'h5;
  localparam logic [3:0] OP_SLL  = 4'h6;
  localparam logic [3:0] OP_SRL  = 4'h7;
  localparam logic [3:0] OP_SRA  = 4'h8;
  localparam logic [3:0] OP_SLT  = 4'h9;
  localparam logic [3:0] OP_SLTU = 4'hA;
  localparam logic [3:0] OP_MUL  = 4'hB;
`ifdef ALU_SAT_EN
  localparam logic [3:0] OP_ADDS = 4'hC;
  localparam logic [3:0] OP_SUBS = 4'hD;
  localparam logic [WIDTH-1:0] SMAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] SMIN = {1'b1, {(WIDTH-1){1'b0}}};
`endif

  typedef enum logic {IDLE, MUL} state_t;

  state_t state_q, state_d;

  logic accept;
  logic is_mul;
  logic mul_done;

  assign accept = in_valid && in_ready;
  assign is_mul = (opcode == OP_MUL);

  // ---------------------------------------------------------------
  // Single-cycle datapath
  // ---------------------------------------------------------------
  logic [WIDTH:0]        add_ext, sub_ext, sll_ext, srl_ext;
  logic signed [WIDTH:0] sra_ext;
  logic                  add_ovf, sub_ovf;
  logic [WIDTH-1:0]      alu_res;
  logic                  alu_carry, alu_ovf, alu_ill, alu_zero;

  assign add_ext = {1'b0, operand_a} + {1'b0, operand_b};
  assign sub_ext = {1'b0, operand_a} - {1'b0, operand_b};
  assign add_ovf = (operand_a[WIDTH-1] == operand_b[WIDTH-1]) &&
                   (add_ext[WIDTH-1] != operand_a[WIDTH-1]);
  assign sub_ovf = (operand_a[WIDTH-1] != operand_b[WIDTH-1]) &&
                   (sub_ext[WIDTH-1] != operand_a[WIDTH-1]);

  // Shifts carry one guard bit so the last bit shifted out falls into it;
  // amounts beyond WIDTH shift the guard bit out too (0, or sign for SRA).
  assign sll_ext = {1'b0, operand_a} << operand_b;
  assign srl_ext = {operand_a, 1'b0} >> operand_b;
  assign sra_ext = $signed({operand_a, 1'b0}) >>> operand_b;

  always_comb begin
    alu_res   = '0;
    alu_carry = 1'b0;
    alu_ovf   = 1'b0;
    alu_ill   = 1'b0;
    case (opcode)
      OP_ADD: begin
        alu_res   = add_ext[WIDTH-1:0];
        alu_carry = add_ext[WIDTH];
        alu_ovf   = add_ovf;
      end
      OP_SUB: begin
        alu_res   = sub_ext[WIDTH-1:0];
        alu_carry = sub_ext[WIDTH];
        alu_ovf   = sub_ovf;
      end
      OP_AND:  alu_res = operand_a & operand_b;
      OP_OR:   alu_res = operand_a | operand_b;
      OP_XOR:  alu_res = operand_a ^ operand_b;
      OP_NOR:  alu_res = ~(operand_a | operand_b);
      OP_SLL: begin
        alu_res   = sll_ext[WIDTH-1:0];
        alu_carry = sll_ext[WIDTH];
      end
      OP_SRL: begin
        alu_res   = srl_ext[WIDTH:1];
        alu_carry = srl_ext[0];
      end
      OP_SRA: begin
        alu_res   = sra_ext[WIDTH:1];
        alu_carry = sra_ext[0];
      end
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(operand_a) < $signed(operand_b))};
      OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (operand_a < operand_b)};
      OP_MUL:  alu_res = '0;
`ifdef ALU_SAT_EN
      OP_ADDS: begin
        alu_res = add_ovf ? (operand_a[WIDTH-1] ? SMIN : SMAX) : add_ext[WIDTH-1:0];
        alu_ovf = add_ovf;
      end
      OP_SUBS: begin
        alu_res = sub_ovf ? (operand_a[WIDTH-1] ? SMIN : SMAX) : sub_ext[WIDTH-1:0];
        alu_ovf = sub_ovf;
      end
`endif
      default: alu_ill = 1'b1;
    endcase
  end

  assign alu_zero = !alu_ill && (alu_res == '0);

  // ---------------------------------------------------------------
  // Shift-add multiplier: {acc_hi, acc_lo} starts as {0, B}; each step
  // adds the multiplicand into the high half when the low bit is set,
  // then shifts the whole pair right by one.
  // ---------------------------------------------------------------
  logic [WIDTH-1:0] mcand_q, acc_hi_q, acc_lo_q;
  logic [SHW-1:0]   cnt_q;
  logic [WIDTH:0]   step_sum;
  logic [WIDTH-1:0] step_hi, step_lo;

  assign step_sum = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, mcand_q} : '0);
  assign step_hi  = step_sum[WIDTH:1];
  assign step_lo  = {step_sum[0], acc_lo_q[WIDTH-1:1]};
  assign mul_done = (state_q == MUL) && (cnt_q == '0);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      mcand_q  <= '0;
      acc_hi_q <= '0;
      acc_lo_q <= '0;
      cnt_q    <= '0;
    end else if (accept && is_mul) begin
      mcand_q  <= operand_a;
      acc_hi_q <= '0;
      acc_lo_q <= operand_b;
      cnt_q    <= SHW'(WIDTH-1);
    end else if (state_q == MUL) begin
      acc_hi_q <= step_hi;
      acc_lo_q <= step_lo;
      cnt_q    <= cnt_q - SHW'(1);
    end
  end

  // ---------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept && is_mul) state_d = MUL;
      MUL:     if (cnt_q == '0)      state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready = (state_q == IDLE) && (!out_valid || out_ready);
    busy     = (state_q == MUL);
  end

  // ---------------------------------------------------------------
  // Result registers
  // ---------------------------------------------------------------
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      out_valid     <= 1'b0;
      result        <= '0;
      result_hi     <= '0;
      zero_flag     <= 1'b0;
      carry_flag    <= 1'b0;
      overflow_flag <= 1'b0;
      illegal_flag  <= 1'b0;
    end else if (accept && !is_mul) begin
      out_valid     <= 1'b1;
      result        <= alu_res;
      result_hi     <= '0;
      zero_flag     <= alu_zero;
      carry_flag    <= alu_carry;
      overflow_flag <= alu_ovf;
      illegal_flag  <= alu_ill;
    end else if (accept) begin
      // previous result was consumed this cycle; nothing valid until MUL ends
      out_valid <= 1'b0;
    end else if (mul_done) begin
      out_valid     <= 1'b1;
      result        <= step_lo;
      result_hi     <= step_hi;
      zero_flag     <= ({step_hi, step_lo} == '0);
      carry_flag    <= (step_hi != '0);
      overflow_flag <= (step_hi != '0);
      illegal_flag  <= 1'b0;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_seq_core.sv
module tb_alu_seq_core;

  localparam int W = 8;

  logic         clock, reset_n;
  logic         in_valid, in_ready;
  logic [3:0]   opcode;
  logic [W-1:0] operand_a, operand_b;
  logic         out_valid, out_ready;
  logic [W-1:0] result, result_hi;
  logic         zero_flag, carry_flag, overflow_flag, illegal_flag, busy;

  int total = 0;
  int bad   = 0;

  alu_seq_core #(.WIDTH(W)) dut (
    .clock(clock), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .operand_a(operand_a), .operand_b(operand_b),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .result_hi(result_hi),
    .zero_flag(zero_flag), .carry_flag(carry_flag),
    .overflow_flag(overflow_flag), .illegal_flag(illegal_flag),
    .busy(busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish (observed=timeout expected=finish)");
    $fatal(1, "watchdog");
  end

  // Reference: {hi, lo, zero, carry, overflow, illegal} from plain integer math
  function automatic logic [19:0] model(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    int ua, ub, sa, sb, r, hi, t;
    bit c, v, ill, z;
    logic [7:0] lo8, hi8;
    ua = a; ub = b;
    sa = int'($signed(a)); sb = int'($signed(b));
    r = 0; hi = 0; c = 0; v = 0; ill = 0;
    case (op)
      4'h0: begin r = ua + ub; c = r > 255; t = sa + sb; v = (t > 127) || (t < -128); end
      4'h1: begin r = ua - ub; c = ua < ub; t = sa - sb; v = (t > 127) || (t < -128); end
      4'h2: r = ua & ub;
      4'h3: r = ua | ub;
      4'h4: r = ua ^ ub;
      4'h5: r = ~(ua | ub);
      4'h6: begin
        r = (ub < 8) ? (ua << ub) : 0;
        c = (ub >= 1 && ub <= 8) && (((ua >> (8 - ub)) & 1) == 1);
      end
      4'h7: begin
        r = (ub < 8) ? (ua >> ub) : 0;
        c = (ub >= 1 && ub <= 8) && (((ua >> (ub - 1)) & 1) == 1);
      end
      4'h8: begin
        r = (ub < 8) ? (sa >>> ub) : ((sa < 0) ? -1 : 0);
        if (ub == 0)      c = 0;
        else if (ub <= 8) c = ((ua >> (ub - 1)) & 1) == 1;
        else              c = sa < 0;
      end
      4'h9: r = (sa < sb) ? 1 : 0;
      4'hA: r = (ua < ub) ? 1 : 0;
      4'hB: begin r = ua * ub; hi = r >> 8; c = hi != 0; v = c; end
`ifdef ALU_SAT_EN
      4'hC: begin
        t = sa + sb;
        if (t > 127)       begin r = 127;  v = 1; end
        else if (t < -128) begin r = -128; v = 1; end
        else               r = t;
      end
      4'hD: begin
        t = sa - sb;
        if (t > 127)       begin r = 127;  v = 1; end
        else if (t < -128) begin r = -128; v = 1; end
        else               r = t;
      end
`endif
      default: ill = 1;
    endcase
    lo8 = r[7:0];
    hi8 = hi[7:0];
    z = !ill && (lo8 == 8'h00) && (hi8 == 8'h00);
    return {hi8, lo8, z, c, v, ill};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [20:0] outs();
    return {out_valid, result_hi, result, zero_flag, carry_flag, overflow_flag, illegal_flag};
  endfunction

  // Called just after a falling edge; leaves in_valid low after the accept.
  task automatic do_op(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b, input string tag);
    logic [19:0] exp;
    int n, busy_bad;
    exp = model(op, a, b);
    in_valid = 1'b1; opcode = op; operand_a = a; operand_b = b; out_ready = 1'b1;
    #1;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clock); #1; n++;
    end
    chk({tag, "_rdy"}, {31'd0, in_ready}, 32'd1);
    @(posedge clock);
    @(negedge clock);
    in_valid = 1'b0;
    if (op == 4'hB) begin
      n = 0; busy_bad = 0;
      while (!out_valid && n < 40) begin
        if (!busy || in_ready) busy_bad++;
        @(negedge clock);
        n++;
      end
      chk({tag, "_lat"}, n, 32'd8);
      chk({tag, "_busy"}, busy_bad, 32'd0);
    end
    chk(tag, {11'd0, outs()}, {11'd0, 1'b1, exp});
  endtask

  logic [20:0] snap;
  int          stable_bad;
  logic [3:0]  rop;
  logic [7:0]  ra, rb;

  initial begin
    reset_n = 1'b0; in_valid = 1'b0; opcode = '0;
    operand_a = '0; operand_b = '0; out_ready = 1'b1;
    repeat (2) @(negedge clock);
    chk("reset_outs", {10'd0, outs(), busy}, 32'd0);
    reset_n = 1'b1;
    @(negedge clock);

    do_op(4'h0, 8'h0F, 8'h01, "add_0f_01");
    chk("add_0f_01_res", {24'd0, result}, 32'h10);
    do_op(4'h0, 8'hFF, 8'h01, "add_ff_01");
    chk("add_ff_01_zc", {30'd0, zero_flag, carry_flag}, 32'b11);
    do_op(4'h1, 8'h80, 8'h01, "sub_80_01");
    chk("sub_80_01_res", {23'd0, result, overflow_flag}, {23'd0, 8'h7F, 1'b1});
    do_op(4'h1, 8'h01, 8'h02, "sub_01_02");
    chk("sub_01_02_res", {23'd0, result, carry_flag}, {23'd0, 8'hFF, 1'b1});
    do_op(4'h8, 8'h90, 8'h02, "sra_90_2");
    chk("sra_90_2_res", {23'd0, result, carry_flag}, {23'd0, 8'hE4, 1'b0});
    do_op(4'h7, 8'h81, 8'h09, "srl_81_9");
    chk("srl_81_9_res", {23'd0, result, zero_flag}, {23'd0, 8'h00, 1'b1});
    do_op(4'h8, 8'h81, 8'h08, "sra_81_8");
    do_op(4'h6, 8'h81, 8'h08, "sll_81_8");
    do_op(4'hB, 8'hC8, 8'h03, "mul_c8_03");
    chk("mul_c8_03_res", {15'd0, result_hi, result, carry_flag}, {15'd0, 8'h02, 8'h58, 1'b1});
    do_op(4'hB, 8'h0F, 8'h11, "mul_0f_11");
    chk("mul_0f_11_res", {15'd0, result_hi, result, carry_flag}, {15'd0, 8'h00, 8'hFF, 1'b0});
    do_op(4'hE, 8'h12, 8'h34, "illegal_e");
    chk("illegal_e_flags", {22'd0, result, illegal_flag, zero_flag}, {22'd0, 8'h00, 1'b1, 1'b0});
    do_op(4'hC, 8'h70, 8'h20, "adds_70_20");
`ifdef ALU_SAT_EN
    chk("adds_70_20_sat", {23'd0, result, overflow_flag}, {23'd0, 8'h7F, 1'b1});
`else
    chk("adds_70_20_ill", {31'd0, illegal_flag}, 32'd1);
`endif

    // Backpressure: hold out_ready low with the next op waiting
    @(negedge clock);
    opcode = 4'h0; operand_a = 8'h0F; operand_b = 8'h01; in_valid = 1'b1; out_ready = 1'b0;
    #1;
    chk("bp_rdy_first", {31'd0, in_ready}, 32'd1);
    @(posedge clock);
    @(negedge clock);
    snap = outs();
    chk("bp_first", {11'd0, snap}, {11'd0, 1'b1, model(4'h0, 8'h0F, 8'h01)});
    opcode = 4'h4; operand_a = 8'h5A; operand_b = 8'h0F;
    stable_bad = 0;
    repeat (5) begin
      #1;
      if (in_ready || (outs() !== snap)) stable_bad++;
      @(negedge clock);
    end
    chk("bp_stable", stable_bad, 32'd0);
    out_ready = 1'b1;
    #1;
    chk("bp_rdy_release", {31'd0, in_ready}, 32'd1);
    @(posedge clock);
    @(negedge clock);
    in_valid = 1'b0;
    chk("bp_next", {11'd0, outs()}, {11'd0, 1'b1, model(4'h4, 8'h5A, 8'h0F)});
    chk("bp_next_res", {24'd0, result}, 32'h55);

    // Back-to-back single-cycle ops at full rate
    do_op(4'h2, 8'hF0, 8'h3C, "b2b_and");
    do_op(4'h9, 8'h80, 8'h01, "b2b_slt");
    do_op(4'hA, 8'h80, 8'h01, "b2b_sltu");

    // Randomised ops against the reference
    for (int i = 0; i < 80; i++) begin
      rop = 4'($urandom_range(0, 15));
      ra  = 8'($urandom);
      rb  = 8'($urandom);
      if (rop >= 4'h6 && rop <= 4'h8 && $urandom_range(0, 3) != 0)
        rb = 8'($urandom_range(0, 10));
      do_op(rop, ra, rb, $sformatf("rnd%0d_op%0h", i, rop));
    end

    // Reset during the 4th multiply cycle
    @(negedge clock);
    opcode = 4'hB; operand_a = 8'hC8; operand_b = 8'h03; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clock);
    @(negedge clock);
    in_valid = 1'b0;
    repeat (3) @(negedge clock);
    reset_n = 1'b0;
    #1;
    chk("midmul_reset_outs", {10'd0, outs(), busy}, 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    #1;
    chk("post_reset_rdy", {31'd0, in_ready}, 32'd1);
    do_op(4'h0, 8'h01, 8'h01, "post_reset_add");
    chk("post_reset_add_res", {24'd0, result}, 32'h02);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
